// File: rtl/set_pattern_driver.sv
// Pattern-ROM driven initiator and checker for the SET candidate engine.
// Issues each ROM pattern to SET and scores the returned candidates.
module set_pattern_driver #(
    parameter int NUM_PAT = 64,
    parameter int ADDR_W  = 6,
    parameter int MAX_ERR = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode_sel,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [23:0]       pat_central,
    input  logic [11:0]       pat_radius,
    input  logic [7:0]        pat_expected,
    output logic              en,
    output logic [23:0]       central,
    output logic [11:0]       radius,
    output logic [1:0]        mode,
    input  logic              busy,
    input  logic              valid,
    input  logic [7:0]        candidate,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_idx,
    output logic              timeout
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_IDLE,
        ISSUE,
        WAIT_VALID,
        CHECK,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] k;
    logic [TW-1:0]     tcnt;
    logic [7:0]        exp_val;
    logic [7:0]        cand_val;
    logic              aborted;

    logic              mismatch;
    logic [7:0]        err_inc;
    logic              hit_max;
    logic              last;
    logic              tmo_hit;

    assign mismatch = (cand_val != exp_val);
    assign err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    assign hit_max  = mismatch && (err_inc == 8'(MAX_ERR));
    assign last     = (k == ADDR_W'(NUM_PAT - 1));
    assign tmo_hit  = (tcnt == TW'(TIMEOUT - 1));

    assign pat_addr = k;
    assign en       = (state == ISSUE);
    assign done     = (state == DONE);
    assign pass     = done && (err_cnt == 8'd0) && !timeout && !aborted;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; a valid response wins over a coincident timeout.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:       if (start) state_n = FETCH;
            FETCH:      state_n = LOAD;
            LOAD:       state_n = WAIT_IDLE;
            WAIT_IDLE:  if (!busy) state_n = ISSUE;
            ISSUE:      state_n = WAIT_VALID;
            WAIT_VALID: begin
                if (valid) begin
                    state_n = CHECK;
                end else if (tmo_hit) begin
                    state_n = DONE;
                end
            end
            CHECK:      state_n = (hit_max || last) ? DONE : FETCH;
            DONE:       if (start) state_n = FETCH;
            default:    state_n = IDLE;
        endcase
    end

    // Run datapath: pattern index, loaded pattern, scoring and timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k        <= '0;
            tcnt     <= '0;
            central  <= '0;
            radius   <= '0;
            mode     <= '0;
            exp_val  <= '0;
            cand_val <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            timeout  <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode     <= mode_sel;
                        k        <= '0;
                        err_cnt  <= '0;
                        fail_idx <= '0;
                        timeout  <= 1'b0;
                        aborted  <= 1'b0;
                    end
                end
                LOAD: begin
                    central <= pat_central;
                    radius  <= pat_radius;
                    exp_val <= pat_expected;
                end
                ISSUE: begin
                    tcnt <= '0;
                end
                WAIT_VALID: begin
                    if (valid) begin
                        cand_val <= candidate;
                    end else if (tmo_hit) begin
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_inc;
                        if (err_cnt == 8'd0) begin
                            fail_idx <= k;
                        end
                    end
                    if (hit_max) begin
                        aborted <= 1'b1;
                    end else if (!last) begin
                        k <= k + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_pattern_driver.sv
// Randomized scoreboard bench for set_pattern_driver.
// Drives a behavioural SET model and a synchronous pattern ROM.
module tb_set_pattern_driver;

    localparam int NP = 64;
    localparam int AW = 6;
    localparam int TO = 16;
    localparam int ME = 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode_sel;
    logic [AW-1:0] pat_addr;
    logic [23:0]   pat_central;
    logic [11:0]   pat_radius;
    logic [7:0]    pat_expected;
    logic          en;
    logic [23:0]   central;
    logic [11:0]   radius;
    logic [1:0]    mode;
    logic          busy;
    logic          valid;
    logic [7:0]    candidate;
    logic          done;
    logic          pass;
    logic [7:0]    err_cnt;
    logic [AW-1:0] fail_idx;
    logic          timeout;

    set_pattern_driver #(
        .NUM_PAT(NP),
        .ADDR_W (AW),
        .MAX_ERR(ME),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode_sel    (mode_sel),
        .pat_addr    (pat_addr),
        .pat_central (pat_central),
        .pat_radius  (pat_radius),
        .pat_expected(pat_expected),
        .en          (en),
        .central     (central),
        .radius      (radius),
        .mode        (mode),
        .busy        (busy),
        .valid       (valid),
        .candidate   (candidate),
        .done        (done),
        .pass        (pass),
        .err_cnt     (err_cnt),
        .fail_idx    (fail_idx),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // SET's candidate-count rule as seen by this bench
    function automatic logic [7:0] set_fn(input logic [23:0] c, input logic [11:0] r,
                                          input logic [1:0] m);
        return (c[7:0] ^ c[15:8] ^ c[23:16] ^ r[11:4]) + {6'd0, m};
    endfunction

    // Pattern ROM with one-cycle synchronous read
    logic [23:0] rom_c [NP];
    logic [11:0] rom_r [NP];
    logic [7:0]  rom_e [NP];
    logic        bad   [NP];

    always @(posedge clk) begin
        pat_central  <= rom_c[pat_addr];
        pat_radius   <= rom_r[pat_addr];
        pat_expected <= rom_e[pat_addr];
    end

    // Behavioural SET: random latency, optional extra busy hold and hang
    int hang_idx = -1;
    int hold_idx = -1;
    int s_cnt;
    int s_hold;
    int s_idx;
    logic [7:0] s_res;

    always @(posedge clk) begin
        if (!rst) begin
            busy   <= 1'b0;
            valid  <= 1'b0;
            candidate <= 8'd0;
            s_cnt  <= 0;
            s_hold <= 0;
            s_idx  <= 0;
        end else begin
            valid <= 1'b0;
            if (start) s_idx <= 0;
            if (en) begin
                busy  <= 1'b1;
                s_cnt <= $urandom_range(1, 6);
                s_res <= set_fn(central, radius, mode);
            end else if (s_cnt != 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) begin
                    if (s_idx != hang_idx) begin
                        valid     <= 1'b1;
                        candidate <= s_res;
                    end
                    if (s_idx + 1 == hold_idx) s_hold <= 20;
                    else busy <= 1'b0;
                    s_idx <= s_idx + 1;
                end
            end else if (s_hold != 0) begin
                s_hold <= s_hold - 1;
                if (s_hold == 1) busy <= 1'b0;
            end
        end
    end

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        int          idx;
    } en_t;

    typedef struct {
        logic          ok;
        logic [7:0]    err;
        logic [AW-1:0] fidx;
        logic          tmo;
    } res_t;

    en_t  en_q[$];
    res_t res_q[$];

    // Monitor: pops expectations whenever the DUT issues or finishes
    int   cyc = 0;
    int   en_count = 0;
    int   last_en_cyc = 0;
    logic prev_en = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        en_t  e;
        res_t r;
        cyc <= cyc + 1;
        if (rst) begin
            if (en) begin
                en_count <= en_count + 1;
                last_en_cyc <= cyc;
                chk("en_width", prev_en, 0);
                chk("en_busy", busy, 0);
                if (en_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_en got idx=%0d exp=none", pat_addr);
                end else begin
                    e = en_q.pop_front();
                    chk("en_idx", pat_addr, e.idx);
                    chk("en_central", central, e.c);
                    chk("en_radius", radius, e.r);
                    chk("en_mode", mode, e.m);
                end
            end
            if (done && !prev_done) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=1 exp=0");
                end else begin
                    r = res_q.pop_front();
                    chk("pass", pass, r.ok);
                    chk("err_cnt", err_cnt, r.err);
                    chk("fail_idx", fail_idx, r.fidx);
                    chk("timeout", timeout, r.tmo);
                    if (r.tmo) begin
                        chk("tmo_delay", (cyc - last_en_cyc >= TO - 1) &&
                                         (cyc - last_en_cyc <= TO + 2), 1);
                    end
                end
            end
        end
        prev_en   <= rst & en;
        prev_done <= rst & done;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, en, 0);
        chk({tag, "_central"}, central, 0);
        chk({tag, "_radius"}, radius, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_pat_addr"}, pat_addr, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_fail_idx"}, fail_idx, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    // One run: build ROM, predict the outcome, start, then wait or reset
    task automatic run(input logic [1:0] m, input int hang, input int hold, input int rst_at);
        int   errs;
        int   first;
        logic tmo;
        logic ab;
        int   base;
        int   n;
        en_t  e;
        res_t r;
        hang_idx = hang;
        hold_idx = hold;
        for (int k = 0; k < NP; k++) begin
            rom_c[k] = 24'($urandom);
            rom_r[k] = 12'($urandom);
            rom_e[k] = set_fn(rom_c[k], rom_r[k], m);
            if (bad[k]) rom_e[k] = rom_e[k] ^ 8'($urandom_range(1, 255));
        end
        errs = 0;
        first = 0;
        tmo = 1'b0;
        ab = 1'b0;
        for (int k = 0; k < NP; k++) begin
            e.c = rom_c[k];
            e.r = rom_r[k];
            e.m = m;
            e.idx = k;
            en_q.push_back(e);
            if (k == hang) begin
                tmo = 1'b1;
                break;
            end
            if (bad[k]) begin
                if (errs == 0) first = k;
                errs++;
                if (errs == ME) begin
                    ab = 1'b1;
                    break;
                end
            end
        end
        r.ok = (errs == 0) && !tmo && !ab;
        r.err = 8'(errs);
        r.fidx = AW'(first);
        r.tmo = tmo;
        res_q.push_back(r);

        base = en_count;
        @(posedge clk);
        #1 start = 1'b1;
        mode_sel = m;
        @(posedge clk);
        #1 start = 1'b0;
        mode_sel = 2'($urandom_range(0, 3));

        if (rst_at >= 0) begin
            n = 0;
            while (en_count - base <= rst_at && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk("rst_point_reached", n < 5000, 1);
            rst = 1'b0;
            @(negedge clk);
            chk_zero("midrun_rst");
            #2 rst = 1'b1;
            en_q.delete();
            res_q.delete();
        end else begin
            n = 0;
            while (!done && n < 20000) begin
                @(negedge clk);
                n++;
            end
            chk("done_reached", done, 1);
            repeat (2) @(negedge clk);
            chk("en_q_drained", en_q.size(), 0);
            chk("res_q_drained", res_q.size(), 0);
            en_q.delete();
            res_q.delete();
        end
    endtask

    task automatic set_bad(input int kind);
        for (int k = 0; k < NP; k++) begin
            case (kind)
                1: bad[k] = (k == 5) || (k == 9);
                2: bad[k] = 1'b1;
                3: bad[k] = ($urandom_range(0, 15) == 0);
                4: bad[k] = (k == 4);
                default: bad[k] = 1'b0;
            endcase
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        mode_sel = 2'b00;
        set_bad(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        set_bad(0); run(2'b01, -1, -1, -1);
        set_bad(1); run(2'($urandom_range(0, 3)), -1, -1, -1);
        set_bad(2); run(2'b10, -1, -1, -1);
        set_bad(0); run(2'b00, -1, 3, -1);
        set_bad(0); run(2'b01, 7, -1, -1);
        set_bad(3); run(2'($urandom_range(0, 3)), -1, -1, -1);
        set_bad(4); run(2'b10, -1, -1, 30);
        set_bad(0); run(2'b11, -1, -1, -1);
        set_bad(3); run(2'($urandom_range(0, 3)), -1, 20, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
